bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
Round-robin arbiter and sequencer that shares one bram_manager instance between N_REQ matrix requesters (e.g. Q/K/V/output engines of the MHA datapath). It latches one request at a time and issues a single-cycle read or write pulse with a stable SEL/MAT. It then waits for the bram_manager completion pulse and returns a one-cycle ACK to the owner. Read data is taken directly from the bram_manager O_MAT bus (broadcast); the arbiter carries only control and write data.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEL_MAX, 64, number of valid BRAM matrix slots; SEL >= SEL_MAX is illegal
TIMEOUT, 1024, max cycles waiting for completion before error ACK

Ports:
I_CLK  in  1  clock
I_RST_N  in  1  asynchronous active-low reset
I_REQ  in  N_REQ  per-requester request level, held until its ACK
I_REQ_WR  in  N_REQ  per-requester op: 1=write, 0=read
I_REQ_SEL  in  N_REQ x 8  per-requester matrix slot
I_REQ_MAT  in  N_REQ x [16][128] x 8  per-requester write matrix
O_GNT  out  N_REQ  one-hot current owner, high ISSUE..DONE
O_ACK  out  N_REQ  one-hot, one-cycle completion pulse to owner
O_ERR  out  1  qualifies O_ACK: 1 = illegal SEL or timeout
O_RD_VLD_PULSE  out  1  to bram_manager I_RD_VLD_PULSE
O_WR_VLD_PULSE  out  1  to bram_manager I_WR_VLD_PULSE
O_SEL  out  8  to bram_manager I_SEL
O_MAT  out  [16][128] x 8  to bram_manager I_MAT
I_BRAM_VLD  in  1  from bram_manager O_VLD (read done, 1-cycle pulse)
I_BRAM_WR_DONE  in  1  from bram_manager O_WR_DONE (write done, 1-cycle pulse)

Behaviour:
- All outputs registered. Reset: state IDLE, rr pointer 0, O_GNT/O_ACK/O_ERR/pulses 0, O_SEL 0, O_MAT all 0, timer 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if |I_REQ, pick the first asserted index at or after the pointer (wrapping); latch idx, wr, sel, mat. If sel < SEL_MAX, go to ISSUE; otherwise go to DONE with err=1 and issue no BRAM pulse.
- ISSUE (exactly 1 cycle): O_GNT[idx]=1, O_SEL/O_MAT = latched values, O_WR_VLD_PULSE=wr, O_RD_VLD_PULSE=!wr. Go to WAIT; timer=0.
- WAIT: O_SEL/O_MAT remain stable; pulses are 0.
  - Read: I_BRAM_VLD -> DONE, err=0.
  - Write: I_BRAM_WR_DONE -> DONE, err=0.
  - A completion pulse of the wrong type is ignored.
  - A completion pulse sampled in the ISSUE cycle is also accepted.
  - timer == TIMEOUT-1 with no completion -> DONE, err=1.
- DONE (1 cycle): O_ACK[idx]=1, O_ERR=err, O_GNT held. Pointer = (idx+1) mod N_REQ. Go to IDLE; O_GNT drops.
- Latency: I_REQ sampled at edge k -> pulse high in cycle k..k+1. Completion sampled at edge m -> ACK in cycle m..m+1. Next grant at earliest edge m+2.
- The requester must drop I_REQ on the edge that samples its ACK. If it is still high in IDLE, it is re-arbitrated with lowest priority (pointer has moved past it).
- Requests from non-owners and changes to the owner's I_REQ_* during ISSUE/WAIT are ignored (values already latched).
- Completion pulses seen in IDLE/DONE are ignored (e.g. a stale pulse after timeout or reset).
- Reset mid-operation returns immediately to the reset state with no ACK. Any BRAM completion that arrives afterwards is ignored.
- At most one BRAM operation is outstanding; there is never a simultaneous RD and WR pulse.

Decomposition:
- Package bram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - constants MAT_ROWS=16, MAT_COLS=128, DATA_W=8, SEL_W=8
  - mat_t typedef [MAT_ROWS][MAT_COLS] of logic [DATA_W-1:0]
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector and pointer. Outputs: valid and index. Parameterised by N_REQ.

Test Plan:
- Single read: reset, I_REQ=4'b0001, WR=0, SEL=0 -> O_RD_VLD_PULSE high exactly 1 cycle with O_SEL=0; bram O_VLD -> O_ACK=4'b0001 one cycle, O_ERR=0.
- Write then read-back: req1 writes SEL=4 with rows 0x55/0x66/0x77/0x88 repeating -> O_WR_VLD_PULSE once with O_MAT matching. On O_WR_DONE, ACK[1]=1. Req1 then reads SEL=4 -> bram O_MAT rows match the written data.
- Contention: I_REQ=4'b1111 held and dropped on each ACK -> grant order 0,1,2,3. Then re-raise all with the pointer at 0 -> 0,1,2,3 again. Every grant is one-hot and there is no overlap.
- Fairness: req0 re-asserts immediately after its ACK while req2 is pending -> req2 is granted before req0.
- Illegal SEL: SEL=64 -> no RD/WR pulse; ACK and O_ERR=1 within 2 cycles of the request.
- Timeout/reset: TIMEOUT=16 with completion withheld -> ACK+ERR at cycle 16 of WAIT; a late O_VLD is ignored. Assert I_RST_N=0 mid-WAIT -> all outputs 0 asynchronously and no ACK.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM arbiter.
// The matrix is one packed vector so it can be registered and cleared with a single assignment.
package bram_arb_pkg;

    localparam int MAT_ROWS = 16;
    localparam int MAT_COLS = 128;
    localparam int DATA_W   = 8;
    localparam int SEL_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef logic [MAT_ROWS-1:0][MAT_COLS-1:0][DATA_W-1:0] mat_t;

    // Widened compare so that SEL_MAX == 2**SEL_W is also handled.
    function automatic logic sel_ok(input logic [SEL_W-1:0] sel, input int sel_max);
        return ({1'b0, sel} < (SEL_W+1)'(sel_max));
    endfunction

endpackage

// File: rtl/bram_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// at or after ptr, wrapping around.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[gi] is the requester index gi positions after the pointer.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi]  = (sum >= (IDX_W+1)'(N_REQ)) ?
                               IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter/sequencer sharing one bram_manager among N_REQ requesters.
// One operation outstanding at a time; read data is broadcast by the bram_manager itself.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SEL_MAX = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                I_CLK,
    input  logic                I_RST_N,
    input  logic [N_REQ-1:0]    I_REQ,
    input  logic [N_REQ-1:0]    I_REQ_WR,
    input  logic [SEL_W-1:0]    I_REQ_SEL [N_REQ],
    input  mat_t                I_REQ_MAT [N_REQ],
    output logic [N_REQ-1:0]    O_GNT,
    output logic [N_REQ-1:0]    O_ACK,
    output logic                O_ERR,
    output logic                O_RD_VLD_PULSE,
    output logic                O_WR_VLD_PULSE,
    output logic [SEL_W-1:0]    O_SEL,
    output mat_t                O_MAT,
    input  logic                I_BRAM_VLD,
    input  logic                I_BRAM_WR_DONE
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               wr_q, wr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               err_q, err_d;
    logic               rd_pulse_q, rd_pulse_d;
    logic               wr_pulse_q, wr_pulse_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    mat_t               mat_q, mat_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               done_hit;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req (I_REQ),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Only the completion type matching the latched operation counts.
    assign done_hit = wr_q ? I_BRAM_WR_DONE : I_BRAM_VLD;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        timer_d    = timer_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        err_d      = 1'b0;
        rd_pulse_d = 1'b0;
        wr_pulse_d = 1'b0;
        sel_d      = sel_q;
        mat_d      = mat_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d = pick_idx;
                    wr_d  = I_REQ_WR[pick_idx];
                    gnt_d = onehot(pick_idx);
                    if (sel_ok(I_REQ_SEL[pick_idx], SEL_MAX)) begin
                        state_d    = ISSUE;
                        sel_d      = I_REQ_SEL[pick_idx];
                        mat_d      = I_REQ_MAT[pick_idx];
                        wr_pulse_d = I_REQ_WR[pick_idx];
                        rd_pulse_d = !I_REQ_WR[pick_idx];
                    end else begin
                        // Illegal slot: answer with an error without touching the BRAM.
                        state_d = DONE;
                        ack_d   = onehot(pick_idx);
                        err_d   = 1'b1;
                        ptr_d   = next_idx(pick_idx);
                    end
                end
            end
            ISSUE: begin
                timer_d = '0;
                if (done_hit) begin
                    state_d = DONE;
                    ack_d   = onehot(idx_q);
                    ptr_d   = next_idx(idx_q);
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_hit || (timer_q == TMR_LAST)) begin
                    state_d = DONE;
                    ack_d   = onehot(idx_q);
                    err_d   = !done_hit;
                    ptr_d   = next_idx(idx_q);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            wr_q       <= 1'b0;
            timer_q    <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rd_pulse_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            sel_q      <= '0;
            mat_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            timer_q    <= timer_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rd_pulse_q <= rd_pulse_d;
            wr_pulse_q <= wr_pulse_d;
            sel_q      <= sel_d;
            mat_q      <= mat_d;
        end
    end

    assign O_GNT          = gnt_q;
    assign O_ACK          = ack_q;
    assign O_ERR          = err_q;
    assign O_RD_VLD_PULSE = rd_pulse_q;
    assign O_WR_VLD_PULSE = wr_pulse_q;
    assign O_SEL          = sel_q;
    assign O_MAT          = mat_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a small behavioural bram_manager model.
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_wr = '0;
    logic [SEL_W-1:0] req_sel [N];
    mat_t             req_mat [N];
    logic [N-1:0]     gnt, ack;
    logic             err, rd_p, wr_p;
    logic [SEL_W-1:0] sel;
    mat_t             omat;
    logic             bram_vld = 1'b0;
    logic             bram_wr_done = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bram_arbiter #(
        .N_REQ   (N),
        .SEL_MAX (64),
        .TIMEOUT (16)
    ) dut (
        .I_CLK          (clk),
        .I_RST_N        (rst_n),
        .I_REQ          (req),
        .I_REQ_WR       (req_wr),
        .I_REQ_SEL      (req_sel),
        .I_REQ_MAT      (req_mat),
        .O_GNT          (gnt),
        .O_ACK          (ack),
        .O_ERR          (err),
        .O_RD_VLD_PULSE (rd_p),
        .O_WR_VLD_PULSE (wr_p),
        .O_SEL          (sel),
        .O_MAT          (omat),
        .I_BRAM_VLD     (bram_vld),
        .I_BRAM_WR_DONE (bram_wr_done)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mat_t mk_pat();
        mat_t m;
        logic [7:0] b;
        for (int r = 0; r < MAT_ROWS; r++) begin
            case (r % 4)
                0:       b = 8'h55;
                1:       b = 8'h66;
                2:       b = 8'h77;
                default: b = 8'h88;
            endcase
            for (int c = 0; c < MAT_COLS; c++) m[r][c] = b;
        end
        return m;
    endfunction

    // bram_manager model: completes bram_lat cycles after a pulse (0 = during ISSUE).
    logic       bram_en = 1'b1;
    int         bram_lat = 2;
    logic       inj_vld = 1'b0;
    logic       inj_wrd = 1'b0;
    mat_t       bram_omat = '0;
    mat_t       mem [int];
    int         pend_cnt = 0;
    logic       op_wr = 1'b0;
    logic [7:0] op_sel = '0;
    mat_t       op_mat = '0;

    task automatic bram_fire();
        if (op_wr) begin
            mem[int'(op_sel)] = op_mat;
            bram_wr_done = 1'b1;
        end else begin
            bram_omat = mem.exists(int'(op_sel)) ? mem[int'(op_sel)] : '0;
            bram_vld  = 1'b1;
        end
    endtask

    initial begin : bram_model
        forever begin
            @(posedge clk);
            #1;
            bram_vld     = 1'b0;
            bram_wr_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) bram_fire();
            end
            if ((rd_p || wr_p) && bram_en) begin
                op_wr  = wr_p;
                op_sel = sel;
                op_mat = omat;
                if (bram_lat == 0) bram_fire();
                else pend_cnt = bram_lat;
            end
            if (inj_vld) bram_vld = 1'b1;
            if (inj_wrd) bram_wr_done = 1'b1;
        end
    end

    int rd_cnt = 0;
    int wr_cnt = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk_eq("gnt_onehot", 32'($onehot0(gnt)), 1);
                chk_eq("rd_wr_excl", 32'(rd_p & wr_p), 0);
                chk_eq("ack_is_owner", 32'((ack == '0) || (ack == gnt)), 1);
                rd_cnt += int'(rd_p);
                wr_cnt += int'(wr_p);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_gnt", 32'(gnt), 0);
        chk_eq("rst_ack", 32'(ack), 0);
        chk_eq("rst_err", 32'(err), 0);
        chk_eq("rst_pulses", 32'({rd_p, wr_p}), 0);
        chk_eq("rst_sel", 32'(sel), 0);
        chk_eq("rst_mat_zero", 32'(omat == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int limit);
        int k = 0;
        while (k < limit) begin
            @(negedge clk);
            k++;
            if (rd_p || wr_p) break;
        end
        chk_eq("pulse_seen", 32'(rd_p | wr_p), 1);
    endtask

    // Waits for an ACK, drops the owner's request, and checks the ACK lasts one cycle.
    task automatic wait_ack(input int limit, output int idx, output logic e, output int lat);
        lat = 0;
        idx = -1;
        e   = 1'b0;
        while (lat < limit) begin
            @(negedge clk);
            lat++;
            if (ack != '0) break;
        end
        chk_eq("ack_seen", 32'(ack != '0), 1);
        if (ack != '0) begin
            chk_eq("ack_onehot", 32'($onehot(ack)), 1);
            for (int i = 0; i < N; i++) if (ack[i]) idx = i;
            e = err;
            req[idx] = 1'b0;
            @(negedge clk);
            chk_eq("ack_one_cycle", 32'(ack), 0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int idx, lat, r0, w0, seen;
        logic e;
        for (int i = 0; i < N; i++) begin
            req_sel[i] = '0;
            req_mat[i] = '0;
        end
        do_reset();

        // single read
        r0 = rd_cnt;
        req_wr[0] = 1'b0; req_sel[0] = 8'd0; req[0] = 1'b1;
        wait_pulse(4);
        chk_eq("t1_rd_pulse", 32'(rd_p), 1);
        chk_eq("t1_wr_pulse", 32'(wr_p), 0);
        chk_eq("t1_sel", 32'(sel), 0);
        chk_eq("t1_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        chk_eq("t1_rd_one_cycle", 32'(rd_p), 0);
        wait_ack(10, idx, e, lat);
        chk_eq("t1_ack_idx", 32'(idx), 0);
        chk_eq("t1_err", 32'(e), 0);
        chk_eq("t1_rd_count", 32'(rd_cnt - r0), 1);

        // write then read back
        w0 = wr_cnt;
        req_wr[1] = 1'b1; req_sel[1] = 8'd4; req_mat[1] = mk_pat(); req[1] = 1'b1;
        wait_pulse(4);
        chk_eq("t2_wr_pulse", 32'(wr_p), 1);
        chk_eq("t2_sel", 32'(sel), 4);
        chk_eq("t2_mat", 32'(omat == mk_pat()), 1);
        chk_eq("t2_gnt", 32'(gnt), 32'h2);
        wait_ack(10, idx, e, lat);
        chk_eq("t2_wack_idx", 32'(idx), 1);
        chk_eq("t2_wack_err", 32'(e), 0);
        chk_eq("t2_wr_count", 32'(wr_cnt - w0), 1);
        req_wr[1] = 1'b0; req_mat[1] = '0; req[1] = 1'b1;
        wait_ack(12, idx, e, lat);
        chk_eq("t2_rack_idx", 32'(idx), 1);
        chk_eq("t2_readback", 32'(bram_omat == mk_pat()), 1);

        // contention, two full rounds from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_wr[i]  = 1'b0;
            req_sel[i] = 8'(8 + i);
        end
        for (int r = 0; r < 2; r++) begin
            req = '1;
            for (int k = 0; k < N; k++) begin
                wait_ack(12, idx, e, lat);
                chk_eq($sformatf("t3_order_r%0d_k%0d", r, k), 32'(idx), 32'(k));
            end
        end

        // fairness: req0 re-raises right after its ACK while req2 waits
        req = 4'b0101;
        wait_ack(12, idx, e, lat);
        chk_eq("t4_first", 32'(idx), 0);
        req[0] = 1'b1;
        wait_ack(12, idx, e, lat);
        chk_eq("t4_second", 32'(idx), 2);
        wait_ack(12, idx, e, lat);
        chk_eq("t4_third", 32'(idx), 0);

        // illegal slot
        r0 = rd_cnt; w0 = wr_cnt;
        req_wr[3] = 1'b0; req_sel[3] = 8'd64; req[3] = 1'b1;
        wait_ack(2, idx, e, lat);
        chk_eq("t5_idx", 32'(idx), 3);
        chk_eq("t5_err", 32'(e), 1);
        chk_eq("t5_no_pulse", 32'((rd_cnt - r0) + (wr_cnt - w0)), 0);
        req_sel[3] = 8'd11;

        // wrong-type completion ignored, then timeout, then a stale read completion
        bram_en = 1'b0;
        req_wr[0] = 1'b0; req_sel[0] = 8'd1; req[0] = 1'b1;
        wait_pulse(4);
        inj_wrd = 1'b1;
        seen = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) inj_wrd = 1'b0;
            seen += int'(ack != '0);
        end
        chk_eq("t6_no_early_ack", 32'(seen), 0);
        @(negedge clk);
        chk_eq("t6_timeout_ack", 32'(ack), 32'h1);
        chk_eq("t6_timeout_err", 32'(err), 1);
        chk_eq("t6_sel_stable", 32'(sel), 1);
        req[0] = 1'b0;
        @(negedge clk);
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen += int'(ack != '0) + int'(gnt != '0);
        end
        chk_eq("t6_stale_ignored", 32'(seen), 0);

        // completion sampled during the ISSUE cycle
        bram_en = 1'b1; bram_lat = 0;
        req_wr[2] = 1'b0; req_sel[2] = 8'd2; req[2] = 1'b1;
        wait_ack(6, idx, e, lat);
        chk_eq("t7_idx", 32'(idx), 2);
        chk_eq("t7_err", 32'(e), 0);
        chk_eq("t7_latency", 32'(lat), 2);

        // reset in the middle of WAIT
        bram_lat = 6;
        req_sel[2] = 8'd7; req[2] = 1'b1;
        wait_pulse(4);
        chk_eq("t8_sel_before", 32'(sel), 7);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t8_gnt_async", 32'(gnt), 0);
        chk_eq("t8_ack_async", 32'(ack), 0);
        chk_eq("t8_pulses_async", 32'({rd_p, wr_p, err}), 0);
        chk_eq("t8_sel_async", 32'(sel), 0);
        chk_eq("t8_mat_async", 32'(omat == '0), 1);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(ack != '0) + int'(gnt != '0);
        end
        chk_eq("t8_late_vld_ignored", 32'(seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
